// File: rtl/axi_fifo_rr_arb_pkg.sv
// Shared FSM encoding and elaboration helpers for the round-robin FIFO arbiter.
// Pure declarations: no logic, no latency, no flow control.
package axi_fifo_rr_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  // Ceiling log2 for sizing counters; clog2(1) = 0.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/axi_fifo_rr_arb_prio_enc.sv
// Rotating priority encoder: first requester after last_grant, wrapping to port 0.
// Purely combinational, zero latency; no flow control of its own.
module rr_prio_enc
  import axi_fifo_rr_arb_pkg::*;
#(
  parameter int NUM_PORTS  = 4,
  parameter int PORT_WIDTH = 2
) (
  input  logic [NUM_PORTS-1:0]  req,
  input  logic [PORT_WIDTH-1:0] last_grant,
  output logic                  any_req,
  output logic [PORT_WIDTH-1:0] next_id
);

  int                    sum;
  logic [PORT_WIDTH-1:0] idx;

  // Offset 1 is checked first, so the last winner has lowest priority.
  always_comb begin
    any_req = 1'b0;
    next_id = '0;
    sum     = 0;
    idx     = '0;
    for (int i = 1; i <= NUM_PORTS; i++) begin
      sum = (int'(last_grant) + i) % NUM_PORTS;
      idx = sum[PORT_WIDTH-1:0];
      if (!any_req && req[idx]) begin
        any_req = 1'b1;
        next_id = idx;
      end
    end
  end

endmodule

// File: rtl/axi_fifo_rr_arb.sv
// Round-robin burst arbiter feeding one AXI-stream FIFO; beats tagged with source id on tuser.
// Latency: accepted beat valid on output next cycle; backpressure: tready follows the output register's free slot, almost_full blocks new grants only.
module axi_fifo_rr_arb
  import axi_fifo_rr_arb_pkg::*;
#(
  parameter int NUM_PORTS  = 4,
  parameter int PORT_WIDTH = 2,
  parameter int DATA_WIDTH = 32,
  parameter int BURST_LEN  = 16
) (
  input  logic                            clk,
  input  logic                            async_reset,
  input  logic [NUM_PORTS-1:0]            s_axis_tvalid,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] s_axis_tdata,
  output logic [NUM_PORTS-1:0]            s_axis_tready,
  input  logic                            fifo_almost_full,
  output logic                            m_axis_tvalid,
  output logic [DATA_WIDTH-1:0]           m_axis_tdata,
  output logic [PORT_WIDTH-1:0]           m_axis_tuser,
  input  logic                            m_axis_tready,
  output logic                            grant_active,
  output logic [PORT_WIDTH-1:0]           grant_id
);

  localparam int              BCW       = clog2(BURST_LEN) + 1;
  localparam logic [BCW-1:0]  LAST_BEAT = BCW'(BURST_LEN - 1);

  state_t                state;
  logic [PORT_WIDTH-1:0] last_grant;
  logic [BCW-1:0]        beat_cnt;
  logic                  any_req;
  logic [PORT_WIDTH-1:0] next_id;
  logic                  out_ready;
  logic                  sel_vld;
  logic [DATA_WIDTH-1:0] sel_dat;
  logic                  accept;
  logic [DATA_WIDTH-1:0] port_dat [NUM_PORTS];

  rr_prio_enc #(
    .NUM_PORTS  (NUM_PORTS),
    .PORT_WIDTH (PORT_WIDTH)
  ) u_prio_enc (
    .req        (s_axis_tvalid),
    .last_grant (last_grant),
    .any_req    (any_req),
    .next_id    (next_id)
  );

  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      port_dat[p] = s_axis_tdata[p*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign out_ready = ~m_axis_tvalid | m_axis_tready;
  assign sel_vld   = s_axis_tvalid[grant_id];
  assign sel_dat   = port_dat[grant_id];
  assign accept    = (state == BURST) && sel_vld && out_ready;

  always_comb begin
    s_axis_tready = '0;
    if (state == BURST) begin
      s_axis_tready[grant_id] = out_ready;
    end
  end

  // A stalled output keeps the grant; only a full burst or a starved source ends it.
  always_ff @(posedge clk or posedge async_reset) begin
    if (async_reset) begin
      state        <= IDLE;
      grant_active <= 1'b0;
      grant_id     <= '0;
      last_grant   <= PORT_WIDTH'(NUM_PORTS - 1);
      beat_cnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req && !fifo_almost_full) begin
            grant_id     <= next_id;
            last_grant   <= next_id;
            beat_cnt     <= '0;
            grant_active <= 1'b1;
            state        <= BURST;
          end
        end
        BURST: begin
          if (accept) begin
            beat_cnt <= beat_cnt + BCW'(1);
            if (beat_cnt == LAST_BEAT) begin
              grant_active <= 1'b0;
              state        <= IDLE;
            end
          end else if (out_ready && !sel_vld) begin
            grant_active <= 1'b0;
            state        <= IDLE;
          end
        end
        default: begin
          grant_active <= 1'b0;
          state        <= IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge async_reset) begin
    if (async_reset) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tuser  <= '0;
    end else if (accept) begin
      m_axis_tvalid <= 1'b1;
      m_axis_tdata  <= sel_dat;
      m_axis_tuser  <= grant_id;
    end else if (m_axis_tready) begin
      m_axis_tvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axi_fifo_rr_arb.sv
// Directed and random stimulus for the round-robin FIFO arbiter, scored against a
// transaction-level model: in-order beat queue, round-robin pick and burst-end rules.
module tb_axi_fifo_rr_arb;

  localparam int N  = 4;
  localparam int PW = 2;
  localparam int DW = 32;
  localparam int BL = 4;

  logic            clk;
  logic            async_reset;
  logic [N-1:0]    s_axis_tvalid;
  logic [N*DW-1:0] s_axis_tdata;
  logic [N-1:0]    s_axis_tready;
  logic            fifo_almost_full;
  logic            m_axis_tvalid;
  logic [DW-1:0]   m_axis_tdata;
  logic [PW-1:0]   m_axis_tuser;
  logic            m_axis_tready;
  logic            grant_active;
  logic [PW-1:0]   grant_id;

  axi_fifo_rr_arb #(
    .NUM_PORTS  (N),
    .PORT_WIDTH (PW),
    .DATA_WIDTH (DW),
    .BURST_LEN  (BL)
  ) dut (
    .clk              (clk),
    .async_reset      (async_reset),
    .s_axis_tvalid    (s_axis_tvalid),
    .s_axis_tdata     (s_axis_tdata),
    .s_axis_tready    (s_axis_tready),
    .fifo_almost_full (fifo_almost_full),
    .m_axis_tvalid    (m_axis_tvalid),
    .m_axis_tdata     (m_axis_tdata),
    .m_axis_tuser     (m_axis_tuser),
    .m_axis_tready    (m_axis_tready),
    .grant_active     (grant_active),
    .grant_id         (grant_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int               vectors = 0;
  int               miscompares = 0;
  logic [N-1:0]     vmask;
  logic [DW-1:0]    cur_dat [N];
  int               ndat [N];
  logic [PW+DW-1:0] exp_q [$];
  int               gnt_log [$];
  int               prev_gnt;
  int               burst_beats;
  int               last_burst;
  int               total_in;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic new_beat(input int p);
    logic [19:0] r;
    logic [7:0]  lo;
    r  = 20'($urandom);
    lo = 8'(8'hA0 + ndat[p]);
    cur_dat[p] = {4'(p), r, lo};
    ndat[p]++;
  endtask

  function automatic int rr_pick(input logic [N-1:0] v, input int prev);
    for (int k = 1; k <= N; k++) begin
      if (v[(prev + k) % N]) return (prev + k) % N;
    end
    return -1;
  endfunction

  // One clock: sample handshakes at negedge, score the post-edge state at posedge+1.
  task automatic cycle();
    logic          pre_ga, pre_af, pre_ord, out_xfer, in_acc, exp_g, done;
    logic [PW-1:0] pre_gid;
    logic [N-1:0]  pre_v, exp_rdy;
    int            exp_id;
    for (int p = 0; p < N; p++) s_axis_tdata[p*DW +: DW] = cur_dat[p];
    s_axis_tvalid = vmask;
    @(negedge clk);
    pre_ga  = grant_active;
    pre_gid = grant_id;
    pre_v   = s_axis_tvalid;
    pre_af  = fifo_almost_full;
    pre_ord = !m_axis_tvalid || m_axis_tready;
    exp_rdy = '0;
    if (pre_ga && pre_ord) exp_rdy[pre_gid] = 1'b1;
    chk("s_tready", s_axis_tready, exp_rdy);
    out_xfer = m_axis_tvalid && m_axis_tready;
    in_acc   = |(s_axis_tvalid & s_axis_tready);
    @(posedge clk);
    #1;
    if (out_xfer && exp_q.size() != 0) void'(exp_q.pop_front());
    if (in_acc) begin
      exp_q.push_back({pre_gid, cur_dat[pre_gid]});
      new_beat(int'(pre_gid));
      burst_beats++;
      total_in++;
    end
    chk("m_tvalid", m_axis_tvalid, (exp_q.size() != 0));
    if (exp_q.size() != 0) chk("m_tuser_tdata", {m_axis_tuser, m_axis_tdata}, exp_q[0]);
    if (!pre_ga) begin
      exp_g = (|pre_v) && !pre_af;
      chk("grant_start", grant_active, exp_g);
      if (exp_g) begin
        exp_id = rr_pick(pre_v, prev_gnt);
        chk("grant_id", grant_id, exp_id);
        gnt_log.push_back(int'(grant_id));
        prev_gnt    = exp_id;
        burst_beats = 0;
      end
    end else begin
      done = (in_acc && burst_beats == BL) || (!in_acc && pre_ord && !pre_v[pre_gid]);
      chk("grant_hold", grant_active, !done);
      chk("grant_id_stable", grant_id, pre_gid);
      if (done) last_burst = burst_beats;
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_m_tvalid"}, m_axis_tvalid, 1'b0);
    chk({tag, "_m_tdata"}, m_axis_tdata, '0);
    chk({tag, "_m_tuser"}, m_axis_tuser, '0);
    chk({tag, "_grant_active"}, grant_active, 1'b0);
    chk({tag, "_grant_id"}, grant_id, '0);
    chk({tag, "_s_tready"}, s_axis_tready, '0);
  endtask

  // Called just after a rising edge; the pulse lies entirely between two edges.
  task automatic pulse_reset();
    async_reset = 1'b1;
    #1;
    check_zero("rst");
    async_reset = 1'b0;
    #1;
    check_zero("post_rst");
    exp_q.delete();
    prev_gnt    = N - 1;
    burst_beats = 0;
  endtask

  task automatic wait_grant(input int p);
    for (int k = 0; k < 60; k++) begin
      if (grant_active && grant_id == PW'(p)) break;
      cycle();
    end
    chk("wait_grant", {grant_active, grant_id}, {1'b1, PW'(p)});
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 60; k++) begin
      if (!grant_active) break;
      cycle();
    end
    chk("wait_idle", grant_active, 1'b0);
  endtask

  initial begin
    int               t0;
    logic [PW+DW-1:0] hold;
    async_reset      = 1'b1;
    fifo_almost_full = 1'b0;
    m_axis_tready    = 1'b1;
    vmask            = '0;
    s_axis_tvalid    = '0;
    s_axis_tdata     = '0;
    total_in         = 0;
    last_burst       = 0;
    for (int p = 0; p < N; p++) begin
      ndat[p] = 0;
      new_beat(p);
    end
    repeat (2) @(posedge clk);
    #1;
    pulse_reset();

    // Single requester on port 2: first beat two cycles after tvalid, one gap per burst.
    vmask = 4'b0100;
    t0 = total_in;
    cycle();
    chk("t1_lat1", m_axis_tvalid, 1'b0);
    cycle();
    chk("t1_lat2", {m_axis_tvalid, m_axis_tuser}, {1'b1, 2'd2});
    chk("t1_first_data", m_axis_tdata[7:0], 8'hA0);
    repeat (3 * (BL + 1) - 2) cycle();
    chk("t1_throughput", total_in - t0, 3 * BL);

    // All ports requesting from reset: grants 0,1,2,3,0 with full bursts.
    @(posedge clk);
    #1;
    pulse_reset();
    vmask = 4'b1111;
    gnt_log.delete();
    t0 = total_in;
    repeat (5 * (BL + 1)) cycle();
    chk("t2_ngrants", gnt_log.size(), 5);
    for (int i = 0; i < 5 && i < gnt_log.size(); i++) chk("t2_order", gnt_log[i], i % N);
    chk("t2_beats", total_in - t0, 5 * BL);

    // Port 1 starves after 3 beats; port 2 follows with a full burst.
    wait_grant(1);
    for (int k = 0; k < 20; k++) begin
      if (burst_beats == 3) break;
      cycle();
    end
    vmask[1] = 1'b0;
    wait_idle();
    chk("t3_short_burst", last_burst, 3);
    vmask = 4'b1111;
    cycle();
    chk("t3_next_grant", {grant_active, grant_id}, {1'b1, 2'd2});
    wait_idle();
    chk("t3_full_burst", last_burst, BL);

    // Output stall mid-burst: beat held, grant kept, inputs not ready.
    wait_grant(3);
    cycle();
    cycle();
    hold = exp_q[0];
    m_axis_tready = 1'b0;
    repeat (5) begin
      cycle();
      chk("t4_hold", {m_axis_tuser, m_axis_tdata}, hold);
      chk("t4_grant", {grant_active, grant_id}, {1'b1, 2'd3});
    end
    m_axis_tready = 1'b1;
    wait_idle();
    chk("t4_burst_len", last_burst, BL);

    // almost_full raised just after a grant: burst completes, then no new grant.
    wait_grant(0);
    fifo_almost_full = 1'b1;
    wait_idle();
    chk("t5_burst_len", last_burst, BL);
    repeat (4) cycle();
    chk("t5_blocked", grant_active, 1'b0);
    chk("t5_no_tready", s_axis_tready, '0);
    fifo_almost_full = 1'b0;
    cycle();
    chk("t5_next_grant", {grant_active, grant_id}, {1'b1, 2'd1});

    // Random traffic, backpressure and almost_full.
    for (int c = 0; c < 400; c++) begin
      for (int p = 0; p < N; p++) vmask[p] = ($urandom_range(0, 9) < 8);
      m_axis_tready    = ($urandom_range(0, 9) < 7);
      fifo_almost_full = ($urandom_range(0, 9) == 0);
      cycle();
    end

    // Reset mid-burst on port 2; port 0 must win afterwards.
    vmask            = 4'b1111;
    m_axis_tready    = 1'b1;
    fifo_almost_full = 1'b0;
    wait_grant(2);
    cycle();
    pulse_reset();
    cycle();
    chk("t6_port0", {grant_active, grant_id}, {1'b1, 2'd0});
    repeat (2 * (BL + 1)) cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
